countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, count rate in Hz; CLK_HZ SHALL be an integer multiple of TICK_HZ.
REQ-003 clock  input  1  system clock; all state SHALL be clocked on its rising edge, with no derived or gated clocks.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  one-cycle request to load preset.
REQ-006 preset  input  28  start value in epoch format.
REQ-007 run  input  1  level; count while high, pause while low.
REQ-008 epoch  output  28  remaining time: [6:0] centiseconds 0..99, [13:7] seconds 0..59, [20:14] minutes 0..59, [27:21] hours 0..23.
REQ-009 running  output  1  high while the state is RUN.
REQ-010 expired  output  1  one-cycle pulse on reaching zero.
REQ-011 alarm  output  1  sticky flag, set with expired, cleared by load or reset.

Function
REQ-012 States SHALL be IDLE, RUN and EXPIRED.
REQ-013 Tick generator: the prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 only in RUN; the wrap cycle is the tick; the prescaler holds while not in RUN and clears on load.
REQ-014 On load, the block SHALL register each preset field clamped to its maximum (cs>99->99, s>59->59, m>59->59, h>23->23), clear alarm, clear the prescaler, and go to IDLE, all visible the next cycle.
REQ-015 load SHALL have priority over a tick and over run in the same cycle, in every state.
REQ-016 IDLE->RUN when run=1 and epoch!=0; IDLE with epoch==0 SHALL ignore run and never expire.
REQ-017 RUN->IDLE when run=0 (pause); epoch and prescaler phase SHALL be retained, and resuming continues the partial tick.
REQ-018 On each tick in RUN, epoch SHALL decrement by one centisecond with borrow: cs 0->99 borrows from s, s 0->59 borrows from m, m 0->59 borrows from h.
REQ-019 A tick with epoch==1 cs SHALL set epoch to 0, pulse expired for exactly one cycle, set alarm and go to EXPIRED, all in the same registered update.
REQ-020 EXPIRED SHALL hold epoch=0 and ignore run until load or reset.
REQ-021 Fields SHALL never leave their legal ranges, and hours SHALL never underflow.

Reset
REQ-022 During reset: epoch=0, state=IDLE, prescaler=0, running=0, expired=0, alarm=0, shadow preset=0.
REQ-023 Reset asserted mid-count SHALL abort immediately, with no expired pulse.

Configuration
REQ-024 Macro COUNTDOWN_TIMER_AUTORELOAD_EN, when defined: load also captures the clamped preset into a shadow register; the terminal tick loads epoch from the shadow instead of 0; the state stays RUN; expired pulses and alarm sets as usual.
REQ-025 With COUNTDOWN_TIMER_AUTORELOAD_EN defined and a zero shadow, the block SHALL behave as without the macro.
REQ-026 Without COUNTDOWN_TIMER_AUTORELOAD_EN, no shadow register SHALL exist and the behaviour is REQ-019/REQ-020.

Structure
REQ-027 The shared package epoch_pkg SHALL hold: field width 7, epoch width 28, field maxima 99/59/59/23, field bit offsets, and the state enum.
REQ-028 The prescaler SHALL be the sub-module tick_gen (inputs clear and enable, output tick); the decrement/borrow logic stays in countdown_timer.

Verification (CLK_HZ=1000, TICK_HZ=100, i.e. tick every 10 cycles)
REQ-029 Load preset s=1 cs=5, run=1 -> after 105 ticks epoch=0, expired high exactly one cycle, alarm=1, running=0; further cycles leave epoch at 0.
REQ-030 Load h=1 m=0 s=0 cs=0, run=1, one tick -> epoch h=0 m=59 s=59 cs=99.
REQ-031 Load all fields =127 -> epoch h=23 m=59 s=59 cs=99; load all zero with run=1 -> stays IDLE, no expired pulse.
REQ-032 Pause check: run low after 3 ticks plus 4 cycles, hold 50 cycles, then run high -> epoch unchanged during the pause, and the next tick arrives 6 cycles after resume.
REQ-033 Load pulse coincident with a tick -> epoch equals preset, no decrement; asserting reset mid-count -> all outputs 0 asynchronously.
REQ-034 With COUNTDOWN_TIMER_AUTORELOAD_EN defined, preset cs=2 and run=1 -> expired pulses every 2 ticks, epoch cycles 2,1,2,1, running stays 1.

Source files
------------

// File: rtl/epoch_pkg.sv
// rtl/epoch_pkg.sv - epoch field layout, limits, state encoding and clamp helper for countdown_timer
package epoch_pkg;

  localparam int FIELD_W = 7;
  localparam int EPOCH_W = 28;

  localparam int CS_LSB = 0;
  localparam int S_LSB  = 7;
  localparam int M_LSB  = 14;
  localparam int H_LSB  = 21;

  localparam logic [FIELD_W-1:0] CS_MAX = 7'd99;
  localparam logic [FIELD_W-1:0] S_MAX  = 7'd59;
  localparam logic [FIELD_W-1:0] M_MAX  = 7'd59;
  localparam logic [FIELD_W-1:0] H_MAX  = 7'd23;

  localparam logic [EPOCH_W-1:0] EPOCH_ONE = 28'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v,
                                                     input logic [FIELD_W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [EPOCH_W-1:0] clamp_epoch(input logic [EPOCH_W-1:0] e);
    logic [EPOCH_W-1:0] r;
    r = '0;
    r[CS_LSB +: FIELD_W] = clamp_field(e[CS_LSB +: FIELD_W], CS_MAX);
    r[S_LSB  +: FIELD_W] = clamp_field(e[S_LSB  +: FIELD_W], S_MAX);
    r[M_LSB  +: FIELD_W] = clamp_field(e[M_LSB  +: FIELD_W], M_MAX);
    r[H_LSB  +: FIELD_W] = clamp_field(e[H_LSB  +: FIELD_W], H_MAX);
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one tick every CLK_HZ/TICK_HZ enabled cycles
module tick_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // The wrap cycle is the tick; a clear in the same cycle suppresses it.
  assign tick = enable && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - h:m:s:cs countdown timer with pause, expiry pulse and sticky alarm
// Optional auto-reload from the loaded preset: COUNTDOWN_TIMER_AUTORELOAD_EN
module countdown_timer
  import epoch_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [EPOCH_W-1:0] preset,
  input  logic               run,
  output logic [EPOCH_W-1:0] epoch,
  output logic               running,
  output logic               expired,
  output logic               alarm
);

  state_e             state_q, state_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               alarm_q, alarm_d;
  logic               expired_q, expired_d;
  logic               tick;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [EPOCH_W-1:0] shadow_q, shadow_d;
`endif

  // One centisecond down with borrow; never called on an all-zero epoch.
  function automatic logic [EPOCH_W-1:0] dec_epoch(input logic [EPOCH_W-1:0] e);
    logic [FIELD_W-1:0] cs, s, m, h;
    logic [EPOCH_W-1:0] r;
    cs = e[CS_LSB +: FIELD_W];
    s  = e[S_LSB  +: FIELD_W];
    m  = e[M_LSB  +: FIELD_W];
    h  = e[H_LSB  +: FIELD_W];
    if (cs != '0) begin
      cs = cs - FIELD_W'(1);
    end else begin
      cs = CS_MAX;
      if (s != '0) begin
        s = s - FIELD_W'(1);
      end else begin
        s = S_MAX;
        if (m != '0) begin
          m = m - FIELD_W'(1);
        end else begin
          m = M_MAX;
          if (h != '0) h = h - FIELD_W'(1);
        end
      end
    end
    r = '0;
    r[CS_LSB +: FIELD_W] = cs;
    r[S_LSB  +: FIELD_W] = s;
    r[M_LSB  +: FIELD_W] = m;
    r[H_LSB  +: FIELD_W] = h;
    return r;
  endfunction

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (load),
    .enable(state_q == ST_RUN),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    epoch_d   = epoch_q;
    alarm_d   = alarm_q;
    expired_d = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    shadow_d  = shadow_q;
`endif
    if (load) begin
      epoch_d  = clamp_epoch(preset);
      alarm_d  = 1'b0;
      state_d  = ST_IDLE;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      shadow_d = clamp_epoch(preset);
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run && (epoch_q != '0)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!run) state_d = ST_IDLE;
          if (tick) begin
            if (epoch_q == EPOCH_ONE) begin
              expired_d = 1'b1;
              alarm_d   = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
              if (shadow_q != '0) begin
                epoch_d = shadow_q;
              end else begin
                epoch_d = '0;
                state_d = ST_EXPIRED;
              end
`else
              epoch_d = '0;
              state_d = ST_EXPIRED;
`endif
            end else begin
              epoch_d = dec_epoch(epoch_q);
            end
          end
        end
        ST_EXPIRED: begin
          epoch_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      epoch_q   <= '0;
      alarm_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epoch_q   <= epoch_d;
      alarm_q   <= alarm_d;
      expired_q <= expired_d;
    end
  end

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign epoch   = epoch_q;
  assign running = (state_q == ST_RUN);
  assign expired = expired_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and random checks of countdown_timer against a total-centisecond model
module tb_countdown_timer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_EXP   = 2;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        load   = 1'b0;
  logic        run    = 1'b0;
  logic [27:0] preset = '0;
  logic [27:0] epoch;
  logic        running;
  logic        expired;
  logic        alarm;

  countdown_timer #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .preset (preset),
    .run    (run),
    .epoch  (epoch),
    .running(running),
    .expired(expired),
    .alarm  (alarm)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_seen = 0;

  // Reference: remaining time as a plain count of centiseconds.
  int m_total, m_phase, m_mode, m_shadow;
  bit m_alarm, m_exp;

  function automatic int clampf(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [27:0] fields(int h, int m, int s, int c);
    return {7'(h), 7'(m), 7'(s), 7'(c)};
  endfunction

  function automatic int preset_total(logic [27:0] p);
    return clampf(int'(p[27:21]), 23) * 360000 + clampf(int'(p[20:14]), 59) * 6000
         + clampf(int'(p[13:7]), 59) * 100 + clampf(int'(p[6:0]), 99);
  endfunction

  function automatic logic [27:0] total_epoch(int t);
    return fields(t / 360000, (t / 6000) % 60, (t / 100) % 60, t % 100);
  endfunction

  task automatic check28(string tag, logic [27:0] obs, logic [27:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(string tag, logic obs, logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(string tag, int obs, int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_phase = 0; m_mode = M_IDLE; m_shadow = 0;
    m_alarm = 1'b0; m_exp = 1'b0;
  endtask

  task automatic model_step();
    m_exp = 1'b0;
    if (load) begin
      m_total  = preset_total(preset);
      m_shadow = AUTORELOAD ? m_total : 0;
      m_alarm  = 1'b0;
      m_mode   = M_IDLE;
      m_phase  = 0;
    end else if (m_mode == M_IDLE) begin
      if (run && m_total != 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_phase = (m_phase + 1) % DIV;
      if (!run) m_mode = M_IDLE;
      if (m_phase == 0) begin
        if (m_total == 1) begin
          m_exp   = 1'b1;
          m_alarm = 1'b1;
          if (m_shadow != 0) m_total = m_shadow;
          else begin
            m_total = 0;
            m_mode  = M_EXP;
          end
        end else begin
          m_total--;
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    check28({tag, ".epoch"}, epoch, total_epoch(m_total));
    check1({tag, ".running"}, running, m_mode == M_RUN);
    check1({tag, ".expired"}, expired, m_exp);
    check1({tag, ".alarm"}, alarm, m_alarm);
  endtask

  task automatic step(string tag);
    model_step();
    @(posedge clock);
    #1;
    check_model(tag);
    if (expired === 1'b1) exp_seen++;
  endtask

  initial begin
    int e0;
    int lat;

    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_model("reset");
    reset = 1'b0;

    // Out-of-range fields clamp; an all-zero load ignores run.
    load = 1'b1; preset = 28'hFFFFFFF;
    step("clamp_load");
    load = 1'b0;
    check28("clamp_epoch", epoch, fields(23, 59, 59, 99));
    load = 1'b1; preset = '0; run = 1'b1;
    step("zero_load");
    load = 1'b0;
    e0 = exp_seen;
    repeat (30) step("zero_idle");
    check1("zero_running", running, 1'b0);
    check_int("zero_no_expire", exp_seen - e0, 0);

    // Full borrow chain from one hour.
    load = 1'b1; preset = fields(1, 0, 0, 0);
    step("borrow_load");
    load = 1'b0;
    repeat (1 + DIV) step("borrow");
    check28("borrow_epoch", epoch, fields(0, 59, 59, 99));

    // 1.05 s countdown to expiry.
    load = 1'b1; preset = fields(0, 0, 1, 5);
    step("c105_load");
    load = 1'b0;
    e0 = exp_seen;
    repeat (1 + 105 * DIV) step("c105");
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
    check28("c105_epoch", epoch, '0);
    check1("c105_expired", expired, 1'b1);
    check1("c105_alarm", alarm, 1'b1);
    check1("c105_running", running, 1'b0);
    repeat (20) step("c105_hold");
    check28("c105_hold_epoch", epoch, '0);
    check_int("c105_pulses", exp_seen - e0, 1);
`else
    check28("c105_reload", epoch, fields(0, 0, 1, 5));
    check1("c105_running", running, 1'b1);
`endif

    // Pause keeps epoch and prescaler phase.
    load = 1'b1; preset = fields(0, 0, 5, 0); run = 1'b1;
    step("pause_load");
    load = 1'b0;
    repeat (1 + 3 * DIV + 4) step("pause_pre");
    run = 1'b0;
    repeat (50) step("pause_hold");
    check28("pause_epoch", epoch, fields(0, 0, 4, 97));
    run = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step("resume");
      if (epoch !== fields(0, 0, 4, 97)) begin
        lat = i;
        break;
      end
    end
    check_int("resume_latency", lat, 6);

    // Load wins over a coincident tick.
    load = 1'b1; preset = fields(0, 0, 0, 50);
    step("lt_load");
    load = 1'b0;
    repeat (DIV) step("lt_pre");
    load = 1'b1; preset = fields(0, 0, 1, 0);
    step("lt_coincide");
    load = 1'b0;
    check28("lt_epoch", epoch, fields(0, 0, 1, 0));
    check1("lt_running", running, 1'b0);

    // Asynchronous reset mid-count.
    repeat (25) step("rst_pre");
    #3 reset = 1'b1;
    #1;
    check28("async_rst_epoch", epoch, '0);
    check1("async_rst_running", running, 1'b0);
    check1("async_rst_expired", expired, 1'b0);
    check1("async_rst_alarm", alarm, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check_model("post_reset");

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    load = 1'b1; preset = fields(0, 0, 0, 2); run = 1'b1;
    step("ar_load");
    load = 1'b0;
    e0 = exp_seen;
    repeat (1 + 4 * DIV) step("ar");
    check_int("ar_pulses", exp_seen - e0, 2);
    check1("ar_running", running, 1'b1);
    check28("ar_epoch", epoch, fields(0, 0, 0, 2));
`endif

    // Random loads, presets and run toggling.
    run = 1'b1;
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        if ($urandom_range(0, 7) == 0) preset = 28'($urandom());
        else preset = fields(0, 0, $urandom_range(0, 1), $urandom_range(0, 9));
      end
      if ($urandom_range(0, 11) == 0) run = ~run;
      step("random");
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
